// File: rtl/jogo_memoria_param.sv
// -----------------------------------------------------------------------------
// jogo_memoria_param
// Sequence-memory game controller. Each round r (0-based) the player must
// repeat sequence entries 0..r, read from an external synchronous ROM. The
// game ends on a correct final round, a wrong play, or a per-play timeout.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous active-low reset
//   iniciar        start / restart request (level)
//   modo           round-count select (latched at game start)
//   chaves[W]      player keys, any nonzero bit is a press
//   endereco[A]    sequence-memory address (current contagem)
//   dado[W]        sequence-memory data, one cycle after endereco
//   pronto         game ended (any end state)
//   acertou        game won
//   errou          game lost (wrong play or timeout)
//   timeout        game lost by timeout
//   db_estado[4]   state code
//   db_rodada[A]   current round
//   db_contagem[A] current play index within the round
//   db_jogada[W]   last captured play
//   db_memoria[W]  sequence-memory data (pass-through)
//   db_tem_jogada  any key currently pressed (combinational)
// -----------------------------------------------------------------------------
module jogo_memoria_param #(
    parameter int unsigned W          = 4,
    parameter int unsigned A          = 4,
    parameter int unsigned RODADAS_M0 = 16,
    parameter int unsigned RODADAS_M1 = 4,
    parameter int unsigned TIMEOUT    = 3000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         modo,
    input  logic [W-1:0] chaves,
    output logic [A-1:0] endereco,
    input  logic [W-1:0] dado,
    output logic         pronto,
    output logic         acertou,
    output logic         errou,
    output logic         timeout,
    output logic [3:0]   db_estado,
    output logic [A-1:0] db_rodada,
    output logic [A-1:0] db_contagem,
    output logic [W-1:0] db_jogada,
    output logic [W-1:0] db_memoria,
    output logic         db_tem_jogada
);

    // Timeout counter must be able to hold TIMEOUT itself (it keeps counting
    // on the edge that leaves ESPERA).
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    // Round limits must fit the A-bit counters so nothing ever wraps.
    if (RODADAS_M0 == 0 || RODADAS_M0 > (2 ** A)) begin : g_bad_rodadas_m0
        $error("jogo_memoria_param: RODADAS_M0 must be in 1..2^A");
    end
    if (RODADAS_M1 == 0 || RODADAS_M1 > (2 ** A)) begin : g_bad_rodadas_m1
        $error("jogo_memoria_param: RODADAS_M1 must be in 1..2^A");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("jogo_memoria_param: TIMEOUT must be at least 1");
    end

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROXIMA     = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hF
    } state_t;

    state_t state;
    state_t next_state;

    logic [A-1:0]  rodada;
    logic [A-1:0]  contagem;
    logic [W-1:0]  jogada;
    logic [TW-1:0] tmo_cnt;
    logic [A-1:0]  lim_m1;       // latched round limit minus one
    logic          prev_or;      // OR(chaves) from the previous cycle

    logic          tem_jogada;
    logic          pulse;

    // Control strobes from the FSM to the datapath
    logic          clr_jogo;
    logic          cap_jogada;
    logic          inc_tmo;
    logic          inc_cont;
    logic          inc_rod;

    // Key activity and its one-cycle rising-edge pulse
    assign tem_jogada = |chaves;
    assign pulse      = tem_jogada & ~prev_or;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INICIAL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes
    always_comb begin
        next_state = state;
        clr_jogo   = 1'b0;
        cap_jogada = 1'b0;
        inc_tmo    = 1'b0;
        inc_cont   = 1'b0;
        inc_rod    = 1'b0;

        case (state)
            INICIAL: begin
                if (iniciar) begin
                    next_state = PREPARA;
                end
            end

            PREPARA: begin
                clr_jogo   = 1'b1;
                next_state = ESPERA;
            end

            // A press in the final allowed cycle still counts
            ESPERA: begin
                inc_tmo = 1'b1;
                if (pulse) begin
                    cap_jogada = 1'b1;
                    next_state = REGISTRA;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    next_state = FIM_TIMEOUT;
                end
            end

            REGISTRA: begin
                next_state = COMPARA;
            end

            COMPARA: begin
                if (jogada != dado) begin
                    next_state = FIM_ERRO;
                end else if (contagem < rodada) begin
                    next_state = PROXIMA;
                end else if (rodada == lim_m1) begin
                    next_state = FIM_ACERTO;
                end else begin
                    next_state = PROX_RODADA;
                end
            end

            PROXIMA: begin
                inc_cont   = 1'b1;
                next_state = ESPERA;
            end

            PROX_RODADA: begin
                inc_rod    = 1'b1;
                next_state = ESPERA;
            end

            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) begin
                    next_state = PREPARA;
                end
            end

            default: begin
                next_state = INICIAL;
            end
        endcase
    end

    // Datapath: counters, captured play, edge register, round limit
    always_ff @(posedge clock) begin
        if (!reset) begin
            rodada   <= '0;
            contagem <= '0;
            jogada   <= '0;
            tmo_cnt  <= '0;
            prev_or  <= 1'b0;
            lim_m1   <= A'(RODADAS_M0 - 1);
        end else begin
            prev_or <= tem_jogada;

            if (clr_jogo) begin
                rodada   <= '0;
                contagem <= '0;
                jogada   <= '0;
                tmo_cnt  <= '0;
                lim_m1   <= modo ? A'(RODADAS_M1 - 1) : A'(RODADAS_M0 - 1);
            end

            if (inc_tmo) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (cap_jogada) begin
                jogada <= chaves;
            end

            if (inc_cont) begin
                contagem <= contagem + A'(1);
                tmo_cnt  <= '0;
            end

            if (inc_rod) begin
                rodada   <= rodada + A'(1);
                contagem <= '0;
                tmo_cnt  <= '0;
            end
        end
    end

    // Game-end flags, registered from the next state so they track db_estado
    always_ff @(posedge clock) begin
        if (!reset) begin
            pronto  <= 1'b0;
            acertou <= 1'b0;
            errou   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            pronto  <= (next_state == FIM_ACERTO) || (next_state == FIM_ERRO) ||
                       (next_state == FIM_TIMEOUT);
            acertou <= (next_state == FIM_ACERTO);
            errou   <= (next_state == FIM_ERRO) || (next_state == FIM_TIMEOUT);
            timeout <= (next_state == FIM_TIMEOUT);
        end
    end

    // Address and debug views
    assign endereco      = contagem;
    assign db_estado     = state;
    assign db_rodada     = rodada;
    assign db_contagem   = contagem;
    assign db_jogada     = jogada;
    assign db_memoria    = dado;
    assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// -----------------------------------------------------------------------------
// tb_jogo_memoria_param
// Directed bench for jogo_memoria_param with default parameters and a small
// synchronous ROM model holding a fixed nonzero sequence.
// -----------------------------------------------------------------------------
module tb_jogo_memoria_param;

    localparam logic [3:0] S_INICIAL  = 4'h0;
    localparam logic [3:0] S_PREPARA  = 4'h1;
    localparam logic [3:0] S_ESPERA   = 4'h2;
    localparam logic [3:0] S_REGISTRA = 4'h3;
    localparam logic [3:0] S_COMPARA  = 4'h4;
    localparam logic [3:0] S_ACERTO   = 4'hA;
    localparam logic [3:0] S_ERRO     = 4'hE;
    localparam logic [3:0] S_TIMEOUT  = 4'hF;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       modo;
    logic [3:0] chaves;
    logic [3:0] endereco;
    logic [3:0] dado;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;
    logic [3:0] db_rodada;
    logic [3:0] db_contagem;
    logic [3:0] db_jogada;
    logic [3:0] db_memoria;
    logic       db_tem_jogada;

    int n_tests = 0;
    int n_fail  = 0;

    jogo_memoria_param dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .modo         (modo),
        .chaves       (chaves),
        .endereco     (endereco),
        .dado         (dado),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado),
        .db_rodada    (db_rodada),
        .db_contagem  (db_contagem),
        .db_jogada    (db_jogada),
        .db_memoria   (db_memoria),
        .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    // Fixed sequence, every entry nonzero so it is a valid key press
    function automatic logic [3:0] rom_val(input logic [3:0] a);
        case (a)
            4'd0:    rom_val = 4'h1;
            4'd1:    rom_val = 4'h2;
            4'd2:    rom_val = 4'h4;
            4'd3:    rom_val = 4'h8;
            4'd4:    rom_val = 4'h3;
            4'd5:    rom_val = 4'h5;
            4'd6:    rom_val = 4'h6;
            4'd7:    rom_val = 4'h9;
            4'd8:    rom_val = 4'hA;
            4'd9:    rom_val = 4'hC;
            4'd10:   rom_val = 4'h7;
            4'd11:   rom_val = 4'hB;
            4'd12:   rom_val = 4'hD;
            4'd13:   rom_val = 4'hE;
            4'd14:   rom_val = 4'hF;
            default: rom_val = 4'h1;
        endcase
    endfunction

    // Synchronous ROM
    always @(posedge clock) dado <= rom_val(endereco);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int k = 0;
        while (db_estado !== s && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (db_estado !== s) check(tag, 32'(db_estado), 32'(s));
    endtask

    // iniciar for one edge; returns at the negedge after entering ESPERA
    task automatic start(input logic m);
        @(negedge clock);
        modo    = m;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
    endtask

    // One press: wait for ESPERA, hold keys for one edge, release
    task automatic play(input logic [3:0] v);
        wait_state(S_ESPERA, 20, "wait_espera");
        chaves = v;
        @(negedge clock);
        chaves = 4'h0;
        @(negedge clock);
    endtask

    task automatic full_game(input int lim);
        for (int r = 0; r < lim; r++) begin
            for (int c = 0; c <= r; c++) begin
                play(rom_val(4'(c)));
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        iniciar = 1'b1;
        modo    = 1'b0;
        chaves  = 4'h0;
        repeat (3) @(negedge clock);

        // Reset wins over iniciar
        check("rst_estado",   32'(db_estado), 32'(S_INICIAL));
        check("rst_pronto",   32'(pronto), 32'd0);
        check("rst_acertou",  32'(acertou), 32'd0);
        check("rst_errou",    32'(errou), 32'd0);
        check("rst_timeout",  32'(timeout), 32'd0);
        check("rst_rodada",   32'(db_rodada), 32'd0);
        check("rst_contagem", 32'(db_contagem), 32'd0);
        check("rst_jogada",   32'(db_jogada), 32'd0);
        check("rst_endereco", 32'(endereco), 32'd0);

        iniciar = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_hold", 32'(db_estado), 32'(S_INICIAL));

        // modo=1 full game; modo toggled mid-game must not matter
        start(1'b1);
        check("a_espera", 32'(db_estado), 32'(S_ESPERA));
        modo = 1'b0;
        full_game(4);
        wait_state(S_ACERTO, 10, "a_wait_fim");
        check("a_estado",   32'(db_estado), 32'(S_ACERTO));
        check("a_pronto",   32'(pronto), 32'd1);
        check("a_acertou",  32'(acertou), 32'd1);
        check("a_errou",    32'(errou), 32'd0);
        check("a_rodada",   32'(db_rodada), 32'd3);
        check("a_contagem", 32'(db_contagem), 32'd3);
        check("a_jogada",   32'(db_jogada), 32'(rom_val(4'd3)));
        repeat (3) @(negedge clock);
        check("a_hold_estado", 32'(db_estado), 32'(S_ACERTO));
        check("a_hold_rodada", 32'(db_rodada), 32'd3);

        // modo=1, round 1, second play wrong
        start(1'b1);
        check("b_restart", 32'(db_rodada), 32'd0);
        play(rom_val(4'd0));
        play(rom_val(4'd0));
        play(rom_val(4'd1) ^ 4'h1);
        wait_state(S_ERRO, 10, "b_wait_fim");
        check("b_estado",   32'(db_estado), 32'(S_ERRO));
        check("b_errou",    32'(errou), 32'd1);
        check("b_timeout",  32'(timeout), 32'd0);
        check("b_pronto",   32'(pronto), 32'd1);
        check("b_acertou",  32'(acertou), 32'd0);
        check("b_rodada",   32'(db_rodada), 32'd1);
        check("b_contagem", 32'(db_contagem), 32'd1);
        check("b_jogada",   32'(db_jogada), 32'h3);

        // No press: ESPERA for exactly 3000 cycles then FIM_TIMEOUT
        start(1'b1);
        check("c_espera0", 32'(db_estado), 32'(S_ESPERA));
        repeat (2999) @(negedge clock);
        check("c_espera2999", 32'(db_estado), 32'(S_ESPERA));
        @(negedge clock);
        check("c_estado",  32'(db_estado), 32'(S_TIMEOUT));
        check("c_timeout", 32'(timeout), 32'd1);
        check("c_errou",   32'(errou), 32'd1);
        check("c_pronto",  32'(pronto), 32'd1);
        check("c_acertou", 32'(acertou), 32'd0);

        // Press on the last allowed cycle wins over timeout
        start(1'b1);
        repeat (2999) @(negedge clock);
        chaves = rom_val(4'd0);
        @(negedge clock);
        chaves = 4'h0;
        check("d_registra", 32'(db_estado), 32'(S_REGISTRA));
        check("d_jogada",   32'(db_jogada), 32'(rom_val(4'd0)));
        @(negedge clock);
        check("d_compara",  32'(db_estado), 32'(S_COMPARA));
        wait_state(S_ESPERA, 5, "d_wait_espera");
        check("d_rodada",   32'(db_rodada), 32'd1);
        check("d_timeout",  32'(timeout), 32'd0);

        // Key held from INICIAL through PREPARA is ignored until re-pressed
        pulse_reset();
        check("e_inicial", 32'(db_estado), 32'(S_INICIAL));
        chaves = 4'h4;
        #1;
        check("e_tem_jogada1", 32'(db_tem_jogada), 32'd1);
        start(1'b1);
        repeat (10) @(negedge clock);
        check("e_held_espera", 32'(db_estado), 32'(S_ESPERA));
        check("e_held_jogada", 32'(db_jogada), 32'd0);
        chaves = 4'h0;
        repeat (2) @(negedge clock);
        check("e_rel_espera",  32'(db_estado), 32'(S_ESPERA));
        check("e_tem_jogada0", 32'(db_tem_jogada), 32'd0);
        chaves = rom_val(4'd0);
        @(negedge clock);
        chaves = 4'h0;
        check("e_registra", 32'(db_estado), 32'(S_REGISTRA));

        // Reach round 2, then reset in ESPERA
        play(rom_val(4'd0));
        play(rom_val(4'd1));
        wait_state(S_ESPERA, 10, "f_wait_espera");
        check("f_rodada2",  32'(db_rodada), 32'd2);
        check("f_contagem", 32'(db_contagem), 32'd0);
        @(negedge clock);
        check("f_memoria",  32'(db_memoria), 32'(rom_val(4'd0)));
        reset   = 1'b0;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        reset   = 1'b1;
        check("f_estado",   32'(db_estado), 32'(S_INICIAL));
        check("f_pronto",   32'(pronto), 32'd0);
        check("f_errou",    32'(errou), 32'd0);
        check("f_rodada",   32'(db_rodada), 32'd0);
        check("f_contagem0", 32'(db_contagem), 32'd0);
        check("f_jogada",   32'(db_jogada), 32'd0);
        start(1'b1);
        check("f_restart_espera", 32'(db_estado), 32'(S_ESPERA));
        check("f_restart_rodada", 32'(db_rodada), 32'd0);
        play(rom_val(4'd0));
        wait_state(S_ESPERA, 10, "f_wait_r1");
        check("f_restart_r1", 32'(db_rodada), 32'd1);

        // modo=0 full game: 16 rounds, 136 plays
        pulse_reset();
        start(1'b0);
        full_game(16);
        wait_state(S_ACERTO, 10, "g_wait_fim");
        check("g_estado",   32'(db_estado), 32'(S_ACERTO));
        check("g_acertou",  32'(acertou), 32'd1);
        check("g_pronto",   32'(pronto), 32'd1);
        check("g_errou",    32'(errou), 32'd0);
        check("g_rodada",   32'(db_rodada), 32'd15);
        check("g_contagem", 32'(db_contagem), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
